// File: rtl/serial_add_unit_if.sv
// Operand/result handshake bundle for serial_add_unit.
// Master drives operands and result-ready; slave is the adder.
interface serial_add_unit_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/serial_add_unit.sv
// Digit-serial adder/subtractor: DIGIT bits per clock,
// WIDTH/DIGIT cycles per operation, valid/ready on both sides.
module serial_add_unit #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic clk,
   input  logic rst_n,
   serial_add_unit_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT-1:0]       da, db;
   logic [DIGIT:0]         dfull;
   logic                   c_msb;
   logic [WIDTH+DIGIT-1:0] shifted;

   // One digit of the full-adder slice; carry into the digit MSB
   // is recovered bit-exactly for the overflow flag.
   always_comb begin
      da      = a_q[DIGIT-1:0];
      db      = b_q[DIGIT-1:0];
      dfull   = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry_q};
      c_msb   = dfull[DIGIT-1] ^ da[DIGIT-1] ^ db[DIGIT-1];
      shifted = {dfull[DIGIT-1:0], acc_q};
   end

   // Control FSM and next-state of all datapath registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b ^ {WIDTH{bus.sub}};
               carry_d = bus.cin ^ bus.sub;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dfull[DIGIT];
            acc_d   = shifted[WIDTH+DIGIT-1:DIGIT];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               sum_d   = shifted[WIDTH+DIGIT-1:DIGIT];
               cout_d  = dfull[DIGIT];
               ovf_d   = c_msb ^ dfull[DIGIT];
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit, bit-serial (DIGIT=1)
// and nibble-serial (DIGIT=4) instances on one clock.
module tb_serial_add_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   serial_add_unit_if #(.WIDTH(8)) b1 ();
   serial_add_unit_if #(.WIDTH(8)) b4 ();

   serial_add_unit #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .bus(b1.slave)
   );
   serial_add_unit #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .bus(b4.slave)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input bit sel, input logic [7:0] a,
                        input logic [7:0] b, input logic ci,
                        input logic s, input logic v);
      if (sel) begin
         b4.a = a; b4.b = b; b4.cin = ci; b4.sub = s; b4.in_valid = v;
      end else begin
         b1.a = a; b1.b = b; b1.cin = ci; b1.sub = s; b1.in_valid = v;
      end
   endtask

   task automatic run_op(input bit sel, input logic [7:0] a,
                         input logic [7:0] b, input logic ci,
                         input logic s, input logic [7:0] es,
                         input logic ec, input logic eo,
                         input int en, input string tag);
      int   lat;
      logic ov;
      @(negedge clk);
      drive(sel, a, b, ci, s, 1'b1);
      chk({tag, "_rdy"}, sel ? b4.in_ready : b1.in_ready, 1);
      @(posedge clk);
      #1;
      drive(sel, a, b, ci, s, 1'b0);
      lat = 0;
      ov  = 1'b0;
      while (!ov && lat < 50) begin
         @(posedge clk);
         lat++;
         #1;
         ov = sel ? b4.out_valid : b1.out_valid;
      end
      chk({tag, "_lat"}, lat, en);
      chk({tag, "_sum"}, sel ? b4.sum : b1.sum, es);
      chk({tag, "_cout"}, sel ? b4.cout : b1.cout, ec);
      chk({tag, "_ovf"}, sel ? b4.ovf : b1.ovf, eo);
      @(negedge clk);
      if (sel) b4.out_ready = 1'b1; else b1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      if (sel) b4.out_ready = 1'b0; else b1.out_ready = 1'b0;
      chk({tag, "_idle"}, sel ? b4.in_ready : b1.in_ready, 1);
   endtask

   logic [7:0] va [4];
   logic [7:0] vb [4];
   logic [7:0] ve [4];
   int         acc_t [4];

   initial begin
      int k;
      int r;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      b1.out_ready = 1'b0;
      b4.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", b1.in_ready, 1);
      chk("rst_out_valid", b1.out_valid, 0);
      chk("rst_sum", b1.sum, 0);
      chk("rst_cout", b1.cout, 0);
      chk("rst_ovf", b1.ovf, 0);
      chk("rst_in_ready4", b4.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(0, 8'h3C, 8'h15, 0, 0, 8'h51, 0, 0, 8, "add_basic");
      run_op(0, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 8, "add_carry");
      run_op(0, 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 8, "add_ovf");
      run_op(0, 8'h05, 8'h03, 0, 1, 8'h02, 1, 0, 8, "sub_d1");
      run_op(1, 8'h10, 8'h20, 0, 1, 8'hF0, 0, 0, 2, "sub_d4");
      run_op(1, 8'h10, 8'h20, 1, 1, 8'hEF, 0, 0, 2, "sub_brw_d4");
      run_op(1, 8'h80, 8'h80, 1, 0, 8'h01, 1, 1, 2, "neg_ovf_d4");
      run_op(1, 8'h7F, 8'h00, 1, 0, 8'h80, 0, 1, 2, "cin_ovf_d4");

      // backpressure: result must hold while out_ready is low
      @(negedge clk);
      drive(0, 8'h12, 8'h34, 0, 0, 1);
      @(posedge clk);
      #1;
      b1.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("bp_valid", b1.out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         b1.a = 8'($urandom);
         b1.b = 8'($urandom);
         b1.in_valid = i[0];
         @(posedge clk);
         #1;
         chk("bp_sum", b1.sum, 8'h46);
         chk("bp_out_valid", b1.out_valid, 1);
         chk("bp_in_ready", b1.in_ready, 0);
      end
      @(negedge clk);
      b1.in_valid = 1'b0;
      b1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      b1.out_ready = 1'b0;
      chk("bp_rel_in_ready", b1.in_ready, 1);
      chk("bp_rel_out_valid", b1.out_valid, 0);
      chk("bp_hold_sum", b1.sum, 8'h46);

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      drive(0, 8'h55, 8'h11, 0, 0, 1);
      @(posedge clk);
      #1;
      b1.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", b1.out_valid, 0);
      chk("arst_in_ready", b1.in_ready, 1);
      chk("arst_sum", b1.sum, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(0, 8'h01, 8'h01, 0, 0, 8'h02, 0, 0, 8, "after_rst");

      // back-to-back with both handshakes held open
      va[0] = 8'h01; vb[0] = 8'h02; ve[0] = 8'h03;
      va[1] = 8'h10; vb[1] = 8'h20; ve[1] = 8'h30;
      va[2] = 8'hAA; vb[2] = 8'h55; ve[2] = 8'hFF;
      va[3] = 8'hF0; vb[3] = 8'h20; ve[3] = 8'h10;
      k = 0;
      r = 0;
      b1.out_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && r < 4; cyc++) begin
         @(negedge clk);
         if (k < 4) drive(0, va[k], vb[k], 0, 0, 1);
         else b1.in_valid = 1'b0;
         if (b1.out_valid) begin
            chk("b2b_sum", b1.sum, ve[r]);
            r++;
         end
         if (k < 4 && b1.in_ready) begin
            acc_t[k] = cyc;
            k++;
         end
      end
      b1.out_ready = 1'b0;
      b1.in_valid = 1'b0;
      chk("b2b_results", r, 4);
      chk("b2b_accepts", k, 4);
      for (int i = 1; i < 4; i++)
         chk("b2b_spacing", acc_t[i] - acc_t[i-1], 10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
